// File: rtl/sw_bcd_updown_counter.sv
// Multi-digit BCD up/down counter stepped by two sampled, edge-detected push switches.
// Latency: Q/CARRY/BORROW update one cycle after a sampled switch level changes.
// Backpressure: none; switch inputs are sampled once per prescaler period.
module sw_bcd_updown_counter #(
  parameter int DIGITS      = 2,
  parameter int SAMPLE_BITS = 19,
  parameter bit WRAP        = 1'b1
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                TSW_UP,
  input  logic                TSW_DN,
  output logic [4*DIGITS-1:0] Q,
  output logic                CARRY,
  output logic                BORROW
);

  localparam int QW = 4 * DIGITS;

  logic [SAMPLE_BITS-1:0] presc_q, presc_d;
  logic                   up_s_q, up_s_d, dn_s_q, dn_s_d;
  logic                   up_d_q, up_d_d, dn_d_q, dn_d_d;
  logic [QW-1:0]          q_q, q_d;
  logic                   carry_q, carry_d, borrow_q, borrow_d;

  logic                   tick;
  logic                   up_p, dn_p;
  logic [QW-1:0]          inc_val, dec_val;
  logic                   inc_ovf, dec_unf;

  // Prescaler, once-per-period switch sampling and one-cycle-delayed copies for edge detect.
  always_comb begin
    tick    = (presc_q == '0);
    presc_d = presc_q + SAMPLE_BITS'(1);
    up_s_d  = tick ? TSW_UP : up_s_q;
    dn_s_d  = tick ? TSW_DN : dn_s_q;
    up_d_d  = up_s_q;
    dn_d_d  = dn_s_q;
    up_p    = up_s_q & ~up_d_q;
    dn_p    = dn_s_q & ~dn_d_q;
  end

  // BCD ripple +1 and -1 of the current count; the running carry/borrow out of the top digit
  // flags the all-9s and all-0s boundaries.
  always_comb begin
    inc_val = q_q;
    dec_val = q_q;
    inc_ovf = 1'b1;
    dec_unf = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (inc_ovf) begin
        if (q_q[4*i +: 4] == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = q_q[4*i +: 4] + 4'd1;
          inc_ovf           = 1'b0;
        end
      end
      if (dec_unf) begin
        if (q_q[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = q_q[4*i +: 4] - 4'd1;
          dec_unf           = 1'b0;
        end
      end
    end
  end

  // Event decode: exactly one pulse steps the count; at a boundary either wrap with a
  // one-cycle carry/borrow or hold (saturate).
  always_comb begin
    q_d      = q_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    if (up_p && !dn_p) begin
      if (!inc_ovf) begin
        q_d = inc_val;
      end else if (WRAP) begin
        q_d     = inc_val;
        carry_d = 1'b1;
      end
    end else if (dn_p && !up_p) begin
      if (!dec_unf) begin
        q_d = dec_val;
      end else if (WRAP) begin
        q_d      = dec_val;
        borrow_d = 1'b1;
      end
    end
  end

  // State registers; reset overrides any pending press or wrap.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      presc_q  <= '0;
      up_s_q   <= 1'b0;
      dn_s_q   <= 1'b0;
      up_d_q   <= 1'b0;
      dn_d_q   <= 1'b0;
      q_q      <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      up_s_q   <= up_s_d;
      dn_s_q   <= dn_s_d;
      up_d_q   <= up_d_d;
      dn_d_q   <= dn_d_d;
      q_q      <= q_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
    end
  end

  assign Q      = q_q;
  assign CARRY  = carry_q;
  assign BORROW = borrow_q;

endmodule

// File: tb/tb_sw_bcd_updown_counter.sv
// Bench for sw_bcd_updown_counter: wrap and saturate instances driven in parallel.
// Reference: decimal integer counts advanced by sampled-press events, compared every cycle.
// Directed scenarios pin the reference with literal values, then randomized switch activity.
module tb_sw_bcd_updown_counter;

  localparam int DIG  = 2;
  localparam int SB   = 3;
  localparam int PER  = 8;
  localparam int MAXV = 99;

  logic       CLK;
  logic       RESET;
  logic       TSW_UP;
  logic       TSW_DN;
  logic [7:0] q_w, q_s;
  logic       cy_w, bw_w, cy_s, bw_s;

  sw_bcd_updown_counter #(.DIGITS(DIG), .SAMPLE_BITS(SB), .WRAP(1'b1)) u_wrap (
    .CLK(CLK), .RESET(RESET), .TSW_UP(TSW_UP), .TSW_DN(TSW_DN),
    .Q(q_w), .CARRY(cy_w), .BORROW(bw_w)
  );

  sw_bcd_updown_counter #(.DIGITS(DIG), .SAMPLE_BITS(SB), .WRAP(1'b0)) u_sat (
    .CLK(CLK), .RESET(RESET), .TSW_UP(TSW_UP), .TSW_DN(TSW_DN),
    .Q(q_s), .CARRY(cy_s), .BORROW(bw_s)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;
  int cy_w_cnt = 0, bw_w_cnt = 0, cy_s_cnt = 0, bw_s_cnt = 0;

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    int t;
    t = v;
    r = '0;
    for (int i = 0; i < DIG; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: phase counts cycles since reset; at phase 0 the switches are sampled, a rise
  // relative to the previous sample of exactly one switch schedules a step for the next edge.
  int m_phase = 0, m_cnt_w = 0, m_cnt_s = 0, m_pend = 0;
  bit m_up = 0, m_dn = 0, m_cy = 0, m_bw = 0;

  always @(posedge CLK) begin
    if (RESET) begin
      m_phase <= 0; m_up <= 0; m_dn <= 0; m_pend <= 0;
      m_cnt_w <= 0; m_cnt_s <= 0; m_cy <= 0; m_bw <= 0;
    end else begin
      m_phase <= (m_phase + 1) % PER;
      m_cy    <= 0;
      m_bw    <= 0;
      m_pend  <= 0;
      if (m_pend == 1) begin
        if (m_cnt_w == MAXV) begin m_cnt_w <= 0; m_cy <= 1; end
        else m_cnt_w <= m_cnt_w + 1;
        if (m_cnt_s != MAXV) m_cnt_s <= m_cnt_s + 1;
      end else if (m_pend == 2) begin
        if (m_cnt_w == 0) begin m_cnt_w <= MAXV; m_bw <= 1; end
        else m_cnt_w <= m_cnt_w - 1;
        if (m_cnt_s != 0) m_cnt_s <= m_cnt_s - 1;
      end
      if (m_phase == 0) begin
        m_up <= TSW_UP;
        m_dn <= TSW_DN;
        if ((TSW_UP && !m_up) && !(TSW_DN && !m_dn)) m_pend <= 1;
        else if ((TSW_DN && !m_dn) && !(TSW_UP && !m_up)) m_pend <= 2;
      end
    end
  end

  // Per-cycle compare of both instances against the reference.
  always @(negedge CLK) begin
    if (chk_en) begin
      cmp("q_wrap", {24'd0, q_w}, {24'd0, to_bcd(m_cnt_w)});
      cmp("carry_wrap", {31'd0, cy_w}, {31'd0, m_cy});
      cmp("borrow_wrap", {31'd0, bw_w}, {31'd0, m_bw});
      cmp("q_sat", {24'd0, q_s}, {24'd0, to_bcd(m_cnt_s)});
      cmp("carry_sat", {31'd0, cy_s}, 32'd0);
      cmp("borrow_sat", {31'd0, bw_s}, 32'd0);
      if (cy_w) cmp("carry_with_zero", {24'd0, q_w}, 32'h00);
      if (bw_w) cmp("borrow_with_99", {24'd0, q_w}, 32'h99);
      if (cy_w) cy_w_cnt++;
      if (bw_w) bw_w_cnt++;
      if (cy_s) cy_s_cnt++;
      if (bw_s) bw_s_cnt++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic press_up();
    TSW_UP = 1'b1; cyc(2*PER);
    TSW_UP = 1'b0; cyc(2*PER);
  endtask

  task automatic press_dn();
    TSW_DN = 1'b1; cyc(2*PER);
    TSW_DN = 1'b0; cyc(2*PER);
  endtask

  task automatic do_reset();
    RESET = 1'b1; cyc(2);
    RESET = 1'b0; cyc(2*PER);
  endtask

  int c0, b0, b1;
  bit found;

  initial begin
    RESET  = 1'b1;
    TSW_UP = 1'b1;
    TSW_DN = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk_en = 1'b1;

    // Reset with the up switch held: clear, then exactly one count after the first tick.
    cyc(2);
    cmp("rst_q", {24'd0, q_w}, 32'h00);
    cmp("rst_carry", {31'd0, cy_w}, 32'd0);
    cmp("rst_borrow", {31'd0, bw_w}, 32'd0);
    RESET = 1'b0;
    cyc(1);
    cmp("rst_lat_q", {24'd0, q_w}, 32'h00);
    cyc(1);
    cmp("rst_first_q", {24'd0, q_w}, 32'h01);

    // Holding the switch for 20 periods gives no further counts.
    cyc(20*PER);
    cmp("hold_q", {24'd0, q_w}, 32'h01);
    TSW_UP = 1'b0;
    cyc(2*PER);

    // Digit ripple and full wrap with one carry pulse.
    for (int i = 0; i < 9; i++) press_up();
    cmp("ripple_q", {24'd0, q_w}, 32'h10);
    c0 = cy_w_cnt;
    for (int i = 0; i < 90; i++) press_up();
    cmp("wrap_q", {24'd0, q_w}, 32'h00);
    cmp("wrap_carry_cnt", 32'(cy_w_cnt - c0), 32'd1);
    cmp("sat_top_q", {24'd0, q_s}, 32'h99);
    cmp("sat_carry_cnt", 32'(cy_s_cnt), 32'd0);

    // Underflow from zero on both instances.
    do_reset();
    b0 = bw_w_cnt;
    b1 = bw_s_cnt;
    press_dn();
    cmp("under_wrap_q", {24'd0, q_w}, 32'h99);
    cmp("under_borrow_cnt", 32'(bw_w_cnt - b0), 32'd1);
    cmp("under_sat_q", {24'd0, q_s}, 32'h00);
    cmp("under_sat_borrow", 32'(bw_s_cnt - b1), 32'd0);

    // Both switches rising together cancel.
    TSW_UP = 1'b1; TSW_DN = 1'b1; cyc(3*PER);
    cmp("simul_wrap_q", {24'd0, q_w}, 32'h99);
    cmp("simul_sat_q", {24'd0, q_s}, 32'h00);
    TSW_UP = 1'b0; TSW_DN = 1'b0; cyc(2*PER);

    // Bounce: toggling every cycle, at most one count per period (reference checks it).
    for (int i = 0; i < 10*PER; i++) begin
      TSW_UP = ~TSW_UP;
      cyc(1);
    end
    TSW_UP = 1'b0;
    cyc(2*PER);

    // Reset coincident with an up pulse at 37.
    do_reset();
    for (int i = 0; i < 37; i++) press_up();
    cmp("pre_mid_q", {24'd0, q_w}, 32'h37);
    TSW_UP = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 3*PER && !found; k++) begin
      @(negedge CLK);
      if (m_pend == 1) found = 1'b1;
    end
    cmp("mid_find_pulse", {31'd0, found}, 32'd1);
    RESET = 1'b1; cyc(1);
    RESET = 1'b0;
    cmp("mid_rst_q", {24'd0, q_w}, 32'h00);
    cmp("mid_rst_carry", {31'd0, cy_w}, 32'd0);
    cyc(2);
    cmp("mid_resume_q", {24'd0, q_w}, 32'h01);
    TSW_UP = 1'b0;
    cyc(2*PER);
    press_up();
    cmp("mid_resume2_q", {24'd0, q_w}, 32'h02);

    // Randomized switch activity with occasional resets.
    for (int i = 0; i < 600; i++) begin
      TSW_UP = 1'($urandom_range(0, 1));
      TSW_DN = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
      if ($urandom_range(0, 99) == 0) RESET = 1'b1;
      cyc(1);
      RESET = 1'b0;
      cyc($urandom_range(0, 12));
    end
    TSW_UP = 1'b0; TSW_DN = 1'b0;
    cyc(2*PER);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
